// File: rtl/decode_idex.sv
// decode_idex
//
// Decode stage of a LEGv8 pipeline together with the ID/EX pipeline register.
// The stage holds a 32 x N register file with two combinational read ports
// and one write port driven from writeback. It also holds the immediate
// generator for LDUR/STUR (9-bit offset) and CBZ (19-bit offset). The
// operands are registered into the execute stage one cycle after decode.
//
// Optional feature (macro DECODE_WB_BYPASS_EN):
//   When defined, a writeback in the same cycle as a decode read of the same
//   register (other than X31) is forwarded straight to the read port.
//   When undefined, reads return the pre-write contents.
//
// Ports:
//   clk           rising-edge clock for register file and ID/EX register
//   reset         asynchronous active-low reset
//   instr_D       instruction in decode (32 bits)
//   PC_D          PC of instr_D (N bits)
//   valid_D       instr_D is a real instruction
//   stall         hold the ID/EX register
//   flush         load a bubble into the ID/EX register (wins over stall)
//   regWrite_W    writeback write enable
//   wa3_W         writeback destination register
//   writeData3_W  writeback data (N bits)
//   PC_E, signImm_E, readData1_E, readData2_E   registered N-bit operands
//   rd_E          registered instr_D[4:0]
//   valid_E       registered valid bit
module decode_idex #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  instr_D,
    input  logic [N-1:0] PC_D,
    input  logic         valid_D,
    input  logic         stall,
    input  logic         flush,
    input  logic         regWrite_W,
    input  logic [4:0]   wa3_W,
    input  logic [N-1:0] writeData3_W,
    output logic [N-1:0] PC_E,
    output logic [N-1:0] signImm_E,
    output logic [N-1:0] readData1_E,
    output logic [N-1:0] readData2_E,
    output logic [4:0]   rd_E,
    output logic         valid_E
);

    logic [N-1:0] regs [32];
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic [N-1:0] read_data1;
    logic [N-1:0] read_data2;
    logic [N-1:0] imm;

    // LDUR/STUR/CBZ keep their second source (store data / tested register)
    // in the Rt field; all other formats use Rm.
    assign ra1 = instr_D[9:5];
    assign ra2 = instr_D[28] ? instr_D[4:0] : instr_D[20:16];

    // Register file storage. X31 is never written, so it stays at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (regWrite_W && (wa3_W != 5'd31)) begin
            regs[wa3_W] <= writeData3_W;
        end
    end

    // Combinational read ports. X31 reads as zero explicitly; the optional
    // bypass lets a same-cycle writeback be seen by the instruction in decode.
    always_comb begin
        read_data1 = (ra1 == 5'd31) ? '0 : regs[ra1];
        read_data2 = (ra2 == 5'd31) ? '0 : regs[ra2];
`ifdef DECODE_WB_BYPASS_EN
        if (regWrite_W && (wa3_W == ra1) && (ra1 != 5'd31)) begin
            read_data1 = writeData3_W;
        end
        if (regWrite_W && (wa3_W == ra2) && (ra2 != 5'd31)) begin
            read_data2 = writeData3_W;
        end
`endif
    end

    // Immediate generation: D-format offset for LDUR/STUR, CB-format offset
    // for CBZ, zero for everything else.
    always_comb begin
        imm = '0;
        if ((instr_D[31:21] == 11'b11111000010) || (instr_D[31:21] == 11'b11111000000)) begin
            imm = {{(N-9){instr_D[20]}}, instr_D[20:12]};
        end else if (instr_D[31:24] == 8'b10110100) begin
            imm = {{(N-19){instr_D[23]}}, instr_D[23:5]};
        end
    end

    // ID/EX register: flush beats stall beats a normal load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_E        <= '0;
            signImm_E   <= '0;
            readData1_E <= '0;
            readData2_E <= '0;
            rd_E        <= '0;
            valid_E     <= 1'b0;
        end else if (flush) begin
            PC_E        <= '0;
            signImm_E   <= '0;
            readData1_E <= '0;
            readData2_E <= '0;
            rd_E        <= '0;
            valid_E     <= 1'b0;
        end else if (!stall) begin
            PC_E        <= PC_D;
            signImm_E   <= imm;
            readData1_E <= read_data1;
            readData2_E <= read_data2;
            rd_E        <= instr_D[4:0];
            valid_E     <= valid_D;
        end
    end

endmodule

// File: tb/tb_decode_idex.sv
// tb_decode_idex
//
// Self-checking bench for decode_idex (N = 64). Directed steps followed by
// randomized steps; every result is compared against a behavioural model of
// the architectural register file and the execute-stage operands.
module tb_decode_idex;

    logic        clk;
    logic        reset;
    logic [31:0] instr_D;
    logic [63:0] PC_D;
    logic        valid_D;
    logic        stall;
    logic        flush;
    logic        regWrite_W;
    logic [4:0]  wa3_W;
    logic [63:0] writeData3_W;
    logic [63:0] PC_E;
    logic [63:0] signImm_E;
    logic [63:0] readData1_E;
    logic [63:0] readData2_E;
    logic [4:0]  rd_E;
    logic        valid_E;

    int passed = 0;
    int total  = 0;

    // Reference state: architectural registers and expected execute operands.
    logic [63:0] m_regs [32];
    logic [63:0] exp_pc, exp_imm, exp_rd1, exp_rd2;
    logic [4:0]  exp_rd;
    logic        exp_valid;

    decode_idex #(.N(64)) dut (
        .clk(clk),
        .reset(reset),
        .instr_D(instr_D),
        .PC_D(PC_D),
        .valid_D(valid_D),
        .stall(stall),
        .flush(flush),
        .regWrite_W(regWrite_W),
        .wa3_W(wa3_W),
        .writeData3_W(writeData3_W),
        .PC_E(PC_E),
        .signImm_E(signImm_E),
        .readData1_E(readData1_E),
        .readData2_E(readData2_E),
        .rd_E(rd_E),
        .valid_E(valid_E)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value an instruction in decode sees when reading register r while a
    // writeback of (we, wa, wd) is happening in the same cycle.
    function automatic logic [63:0] modelRead(input logic [4:0] r, input logic we,
                                              input logic [4:0] wa, input logic [63:0] wd);
        if (r == 5'd31) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wa == r) return wd;
`endif
        return m_regs[r];
    endfunction

    // Immediate from the opcode rules, sign extension done via signed casts.
    function automatic logic [63:0] modelImm(input logic [31:0] ins);
        logic signed [8:0]  d_off;
        logic signed [18:0] cb_off;
        longint             v;
        d_off  = ins[20:12];
        cb_off = ins[23:5];
        v = 0;
        if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) v = longint'(d_off);
        else if (ins[31:24] == 8'hB4) v = longint'(cb_off);
        return 64'(v);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".PC_E"},        PC_E,        exp_pc);
        check({tag, ".signImm_E"},   signImm_E,   exp_imm);
        check({tag, ".readData1_E"}, readData1_E, exp_rd1);
        check({tag, ".readData2_E"}, readData2_E, exp_rd2);
        check({tag, ".rd_E"},        64'(rd_E),   64'(exp_rd));
        check({tag, ".valid_E"},     64'(valid_E), 64'(exp_valid));
    endtask

    // One clock cycle: drive at the falling edge (releasing reset if held),
    // predict the execute operands, update the model registers, and return
    // 1 unit after the rising edge.
    task automatic applyStimulus(input logic [31:0] ins, input logic [63:0] pc,
                                 input logic v, input logic st, input logic fl,
                                 input logic we, input logic [4:0] wa, input logic [63:0] wd);
        logic [4:0] r2;
        @(negedge clk);
        reset        = 1'b1;
        instr_D      = ins;
        PC_D         = pc;
        valid_D      = v;
        stall        = st;
        flush        = fl;
        regWrite_W   = we;
        wa3_W        = wa;
        writeData3_W = wd;
        r2 = ins[28] ? ins[4:0] : ins[20:16];
        if (fl) begin
            {exp_pc, exp_imm, exp_rd1, exp_rd2} = '0;
            exp_rd    = '0;
            exp_valid = 1'b0;
        end else if (!st) begin
            exp_pc    = pc;
            exp_imm   = modelImm(ins);
            exp_rd1   = modelRead(ins[9:5], we, wa, wd);
            exp_rd2   = modelRead(r2, we, wa, wd);
            exp_rd    = ins[4:0];
            exp_valid = v;
        end
        if (we && wa != 5'd31) m_regs[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        {exp_pc, exp_imm, exp_rd1, exp_rd2} = '0;
        exp_rd    = '0;
        exp_valid = 1'b0;
    endtask

    function automatic logic [31:0] addInstr(input logic [4:0] rd, input logic [4:0] rn,
                                             input logic [4:0] rm);
        return {11'b10001011000, rm, 6'd0, rn, rd};
    endfunction

    logic [31:0] ins_r;

    initial begin
        reset = 1'b1;
        {instr_D, PC_D, valid_D, stall, flush, regWrite_W, wa3_W, writeData3_W} = '0;
        clearModel();

        // Reset state, asserted and held across a couple of edges.
        #2 reset = 1'b0;
        #1 checkOutput("reset_async");
        instr_D = addInstr(5'd1, 5'd2, 5'd3);
        PC_D = 64'h40; valid_D = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkOutput("reset_held");

        // Write X5, then ADD X1,X5,X5 (first capture after reset release).
        applyStimulus(32'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234);
        checkOutput("first_capture");
        applyStimulus(addInstr(5'd1, 5'd5, 5'd5), 64'h100, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        checkOutput("add_x5");
        check("add_x5.rd1_const", readData1_E, 64'h1234);
        check("add_x5.rd2_const", readData2_E, 64'h1234);
        check("add_x5.rd_const",  64'(rd_E), 64'd1);

        // Stall three cycles with different decode inputs: E holds.
        for (int i = 0; i < 3; i++) begin
            applyStimulus({11'h7C2, 9'h0F, 2'b00, 5'd5, 5'd9}, 64'h200 + 64'(i), 1'b1,
                          1'b1, 1'b0, 1'b1, 5'd10 + 5'(i), 64'hBEEF);
            checkOutput("stall");
            check("stall.pc_const", PC_E, 64'h100);
        end

        // Stall and flush together: bubble.
        applyStimulus(addInstr(5'd4, 5'd5, 5'd5), 64'h300, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0);
        checkOutput("stall_flush");
        check("stall_flush.valid_const", 64'(valid_E), 64'd0);

        // LDUR with offset 0x1F8 and CBZ with offset 0x10.
        applyStimulus({11'h7C2, 9'h1F8, 2'b00, 5'd5, 5'd6}, 64'h400, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        checkOutput("ldur");
        check("ldur.imm_const", signImm_E, 64'hFFFF_FFFF_FFFF_FFF8);
        applyStimulus({8'hB4, 19'h00010, 5'd5}, 64'h404, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        checkOutput("cbz");
        check("cbz.imm_const", signImm_E, 64'h10);

        // X31 write is discarded and X31 reads zero on both ports.
        applyStimulus(32'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 64'hFFFF);
        applyStimulus(addInstr(5'd2, 5'd31, 5'd31), 64'h500, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        checkOutput("x31");
        check("x31.rd1_const", readData1_E, 64'd0);
        check("x31.rd2_const", readData2_E, 64'd0);

        // Same-cycle write and read of X7.
        applyStimulus(32'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 64'h55);
        applyStimulus(addInstr(5'd3, 5'd7, 5'd7), 64'h600, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 64'hAA);
        checkOutput("wb_same_cycle");
`ifdef DECODE_WB_BYPASS_EN
        check("wb_same_cycle.rd1_const", readData1_E, 64'hAA);
`else
        check("wb_same_cycle.rd1_const", readData1_E, 64'h55);
`endif

        // Asynchronous reset between edges while valid_E=1.
        applyStimulus(addInstr(5'd8, 5'd5, 5'd7), 64'h700, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        check("pre_reset.valid_const", 64'(valid_E), 64'd1);
        #2 reset = 1'b0;
        clearModel();
        #1 checkOutput("mid_reset");
        applyStimulus(addInstr(5'd1, 5'd5, 5'd7), 64'h800, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        checkOutput("post_reset_regs");
        check("post_reset.rd1_const", readData1_E, 64'd0);

        // Randomized steps.
        for (int i = 0; i < 300; i++) begin
            ins_r = $urandom;
            case ($urandom_range(0, 3))
                1: ins_r[31:21] = 11'h7C2;
                2: ins_r[31:21] = 11'h7C0;
                3: ins_r[31:24] = 8'hB4;
                default: ;
            endcase
            applyStimulus(ins_r, {$urandom, $urandom}, 1'($urandom),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                          1'($urandom), 5'($urandom), {$urandom, $urandom});
            checkOutput("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decode_idex.md
DECODE_IDEX -- requirements
Module: decode_idex

Interface
REQ-001: Parameter N, default 64, sets the datapath width of PC, immediate and register data.
REQ-002: clk  input  1  rising-edge clock for the register file and the ID/EX register.
REQ-003: reset  input  1  asynchronous, active-low reset.
REQ-004: instr_D  input  32  LEGv8 instruction in decode.
REQ-005: PC_D  input  N  PC of instr_D.
REQ-006: valid_D  input  1  instr_D is a real instruction.
REQ-007: stall  input  1  hold the ID/EX register.
REQ-008: flush  input  1  insert a bubble into the ID/EX register.
REQ-009: regWrite_W  input  1  writeback write enable.
REQ-010: wa3_W  input  5  writeback destination register.
REQ-011: writeData3_W  input  N  writeback data.
REQ-012: PC_E, signImm_E, readData1_E, readData2_E  output  N each  registered operands to execute.
REQ-013: rd_E  output  5  registered instr_D[4:0].
REQ-014: valid_E  output  1  registered valid bit.

Function
REQ-015: The block SHALL contain a 32-entry x N-bit register file; reads of register 31 SHALL return 0.
REQ-016: The register file SHALL write writeData3_W to entry wa3_W on the rising clk edge when regWrite_W=1; writes to register 31 SHALL be discarded.
REQ-017: Read address ra1 SHALL be instr_D[9:5].
REQ-018: Read address ra2 SHALL be instr_D[4:0] when instr_D[28]=1 (LDUR/STUR/CBZ), otherwise instr_D[20:16].
REQ-019: Register-file reads SHALL be combinational.
REQ-020: If instr_D[31:21] is 11111000010 (LDUR) or 11111000000 (STUR), the immediate SHALL be instr_D[20:12] sign-extended to N bits.
REQ-021: If instr_D[31:24] is 10110100 (CBZ), the immediate SHALL be instr_D[23:5] sign-extended to N bits.
REQ-022: For every other opcode, the immediate SHALL be 0.
REQ-023: The ID/EX register SHALL capture {PC_D, immediate, read data 1, read data 2, instr_D[4:0], valid_D} on each rising edge, so latency from decode to the E outputs is 1 cycle.
REQ-024: Priority SHALL be flush > stall > load.
REQ-025: On flush=1, the next edge SHALL clear valid_E and all other E outputs to 0.
REQ-026: On stall=1 with flush=0, all E outputs SHALL hold their values.
REQ-027: When flush and stall are both asserted, flush SHALL win and a bubble SHALL be loaded.
REQ-028: A register-file write SHALL proceed regardless of stall or flush.

Reset
REQ-029: While reset=0, asynchronously, all E outputs and valid_E SHALL be 0 and all 32 register-file entries SHALL be 0.
REQ-030: Reset asserted mid-operation SHALL discard any in-flight or held ID/EX contents.
REQ-031: The first capture SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-032: Macro DECODE_WB_BYPASS_EN, when defined, SHALL forward writeData3_W to a read port in the same cycle if regWrite_W=1, wa3_W equals that port's address, and the address is not 31.
REQ-033: When DECODE_WB_BYPASS_EN is undefined, reads SHALL return the pre-write register content; the written value becomes visible starting the cycle after the write.

Verification
REQ-034: Reset, then write X5=0x1234 and decode ADD X1,X5,X5 -> after 1 cycle readData1_E=readData2_E=0x1234, rd_E=1, valid_E=1.
REQ-035: Decode LDUR with instr_D[20:12]=0x1F8 -> signImm_E=0xFFFFFFFFFFFFFFF8. Decode CBZ with instr_D[23:5]=0x00010 -> signImm_E=0x10.
REQ-036: Write X31=0xFFFF, then read X31 on both ports -> readData1_E=readData2_E=0.
REQ-037: In the same cycle, regWrite_W=1, wa3_W=7, data=0xAA, and decode reads X7 (old value 0x55):
- with DECODE_WB_BYPASS_EN defined -> readData1_E=0xAA;
- without it -> readData1_E=0x55.
REQ-038: Load a valid instruction, then:
- assert stall for 3 cycles -> E outputs unchanged;
- assert stall and flush together -> valid_E=0 and all E outputs 0 next cycle.
REQ-039: Drop reset asynchronously between edges while valid_E=1 -> valid_E and all E outputs go to 0 immediately, and the register file reads 0.
